// File: rtl/decode_stage_p.sv
// Decode stage: GPR file with write-through reads, jump/branch resolution in decode,
// load-use hazard bubbles, wrong-path squash and a valid-tagged decode/execute register.
module decode_stage_p #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned LINK_REG = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic              uses_rs,
  input  logic              uses_rt,
  input  logic [10:0]       imm,
  input  logic [1:0]        imm_sel,
  input  logic              b_imm,
  input  logic              fwd_rs,
  input  logic              fwd_rt,
  input  logic [DATA_W-1:0] fwd_rs_data,
  input  logic [DATA_W-1:0] fwd_rt_data,
  input  logic [DATA_W-1:0] pc_next,
  input  logic              branch,
  input  logic              jump,
  input  logic              link,
  input  logic              base_pc,
  input  logic              off_long,
  input  logic [1:0]        cond,
  input  logic              ex_load,
  input  logic [ADDR_W-1:0] ex_wr_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              stall,
  input  logic              flush,
  output logic              redirect,
  output logic [DATA_W-1:0] target,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LinkAddr = ADDR_W'(LINK_REG);

  logic [DATA_W-1:0] regs [NumRegs];
  logic              squash_q;

  logic [DATA_W-1:0] rs_op, rt_op, ext_imm, offset, base;
  logic              haz, conflict, go, cond_true;

  // Operand read: forward beats write-through beats the stored value.
  always_comb begin
    rs_op = regs[rs_addr];
    if (wr_en && wr_addr == rs_addr) rs_op = wr_data;
    if (fwd_rs) rs_op = fwd_rs_data;
    rt_op = regs[rt_addr];
    if (wr_en && wr_addr == rt_addr) rt_op = wr_data;
    if (fwd_rt) rt_op = fwd_rt_data;
  end

  always_comb begin
    ext_imm = '0;
    unique case (imm_sel)
      2'b00:   ext_imm = {{(DATA_W-5){imm[4]}}, imm[4:0]};
      2'b01:   ext_imm = {{(DATA_W-8){imm[7]}}, imm[7:0]};
      2'b10:   ext_imm = {{(DATA_W-11){imm[10]}}, imm[10:0]};
      default: ext_imm = {{(DATA_W-8){1'b0}}, imm[7:0]};
    endcase
  end

  always_comb begin
    offset = off_long ? {{(DATA_W-11){imm[10]}}, imm[10:0]} : {{(DATA_W-8){imm[7]}}, imm[7:0]};
    base   = base_pc ? pc_next : rs_op;
    target = base + offset;
    cond_true = 1'b0;
    unique case (cond)
      2'b00:   cond_true = (rs_op == '0);
      2'b01:   cond_true = (rs_op != '0);
      2'b10:   cond_true = rs_op[DATA_W-1];
      default: cond_true = ~rs_op[DATA_W-1];
    endcase
  end

  always_comb begin
    haz = in_valid & ex_load &
          ((uses_rs & (ex_wr_addr == rs_addr)) | (uses_rt & (ex_wr_addr == rt_addr)));
    // Link write needs the single register write port, so wait for writeback to go idle.
    conflict = link & jump & wr_en;
    in_ready = squash_q ? ~stall : (~stall & ~haz & ~conflict);
    go       = in_valid & in_ready & ~squash_q;
    redirect = ~rst & go & (jump | (branch & cond_true));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NumRegs; i++) regs[i] <= '0;
    end else begin
      if (wr_en) regs[wr_addr] <= wr_data;
      if (go && jump && link) regs[LinkAddr] <= pc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      squash_q <= 1'b0;
    end else if (redirect) begin
      squash_q <= 1'b1;
    end else if (squash_q && !stall) begin
      squash_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (!stall) begin
      out_valid <= go;
      if (go) begin
        out_a <= rs_op;
        out_b <= b_imm ? ext_imm : rt_op;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage_p.sv
// Directed self-checking bench for decode_stage_p using immediate assertions.
module tb_decode_stage_p;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [2:0]  rs_addr, rt_addr, ex_wr_addr, wr_addr;
  logic        uses_rs, uses_rt, b_imm, fwd_rs, fwd_rt;
  logic [10:0] imm;
  logic [1:0]  imm_sel, cond;
  logic [15:0] fwd_rs_data, fwd_rt_data, pc_next, wr_data, target, out_a, out_b;
  logic        branch, jump, link, base_pc, off_long, ex_load, wr_en, stall, flush;
  logic        redirect, out_valid;

  int checks = 0;
  int fails  = 0;

  decode_stage_p #(.DATA_W(16), .ADDR_W(3), .LINK_REG(7)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .uses_rs(uses_rs), .uses_rt(uses_rt),
    .imm(imm), .imm_sel(imm_sel), .b_imm(b_imm), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
    .fwd_rs_data(fwd_rs_data), .fwd_rt_data(fwd_rt_data), .pc_next(pc_next),
    .branch(branch), .jump(jump), .link(link), .base_pc(base_pc), .off_long(off_long),
    .cond(cond), .ex_load(ex_load), .ex_wr_addr(ex_wr_addr), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .stall(stall), .flush(flush),
    .redirect(redirect), .target(target), .out_valid(out_valid), .out_a(out_a), .out_b(out_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; leave time 1 after the edge for sampling and driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; rs_addr = 0; rt_addr = 0; uses_rs = 0; uses_rt = 0; imm = 0; imm_sel = 0;
    b_imm = 0; fwd_rs = 0; fwd_rt = 0; fwd_rs_data = 0; fwd_rt_data = 0; pc_next = 0;
    branch = 0; jump = 0; link = 0; base_pc = 0; off_long = 0; cond = 0; ex_load = 0;
    ex_wr_addr = 0; wr_en = 0; wr_addr = 0; wr_data = 0; stall = 0; flush = 0;
  endtask

  logic [15:0] imm_exp [4];

  initial begin
    idle();
    rst = 1;
    // Reset with a jump presented: redirect must stay low.
    in_valid = 1; jump = 1;
    #1;
    check("rst_redirect", {15'd0, redirect}, 16'd0);
    step(); step();
    check("rst_out_valid", {15'd0, out_valid}, 16'd0);
    check("rst_out_a", out_a, 16'h0000);
    check("rst_out_b", out_b, 16'h0000);
    rst = 0; idle();

    // Write-through: R3 written in the cycle it is read.
    in_valid = 1; rs_addr = 3; uses_rs = 1; wr_en = 1; wr_addr = 3; wr_data = 16'h1234;
    #1;
    check("wt_in_ready", {15'd0, in_ready}, 16'd1);
    step();
    wr_en = 0;
    check("wt_out_valid", {15'd0, out_valid}, 16'd1);
    check("wt_out_a", out_a, 16'h1234);
    check("wt_out_b", out_b, 16'h0000);

    // Immediate extension modes on imm = 0x5E3.
    imm_exp[0] = 16'h0003; imm_exp[1] = 16'hFFE3; imm_exp[2] = 16'hFDE3; imm_exp[3] = 16'h00E3;
    idle(); in_valid = 1; b_imm = 1; imm = 11'h5E3;
    for (int i = 0; i < 4; i++) begin
      imm_sel = 2'(i);
      step();
      check($sformatf("imm_sel%0d", i), out_b, imm_exp[i]);
    end

    // Load-use hazard on rt = R2: one bubble, then the instruction proceeds.
    idle(); in_valid = 1; rt_addr = 2; uses_rt = 1; ex_load = 1; ex_wr_addr = 2;
    fwd_rt = 1; fwd_rt_data = 16'hBEEF;
    #1;
    check("haz_in_ready", {15'd0, in_ready}, 16'd0);
    step();
    check("haz_bubble", {15'd0, out_valid}, 16'd0);
    ex_load = 0;
    #1;
    check("haz_release_ready", {15'd0, in_ready}, 16'd1);
    step();
    check("haz_proceed_valid", {15'd0, out_valid}, 16'd1);
    check("haz_proceed_b", out_b, 16'hBEEF);

    // Hazard ignored when the matching source is not used.
    idle(); in_valid = 1; rs_addr = 2; ex_load = 1; ex_wr_addr = 2;
    #1;
    check("nohaz_in_ready", {15'd0, in_ready}, 16'd1);

    // Jump through rs with long offset: 0x1000 + sext(0x400) = 0x0C00 (checked only, not taken).
    idle(); in_valid = 1; jump = 1; fwd_rs = 1; fwd_rs_data = 16'h1000; off_long = 1;
    imm = 11'h400;
    #1;
    check("jr_redirect", {15'd0, redirect}, 16'd1);
    check("jr_target", target, 16'h0C00);
    // GEZ on a negative operand is not taken.
    jump = 0; branch = 1; cond = 2'b11; fwd_rs_data = 16'h8000;
    #1;
    check("bgez_not_taken", {15'd0, redirect}, 16'd0);
    in_valid = 0;
    step();

    // BLTZ taken, pc-relative; following slot squashed.
    idle(); in_valid = 1; branch = 1; cond = 2'b10; fwd_rs = 1; fwd_rs_data = 16'h8000;
    base_pc = 1; pc_next = 16'h0040; imm = 11'h0FE;
    #1;
    check("bltz_redirect", {15'd0, redirect}, 16'd1);
    check("bltz_target", target, 16'h003E);
    step();
    check("bltz_out_a", out_a, 16'h8000);
    idle(); in_valid = 1; jump = 1; rs_addr = 3;
    #1;
    check("squash_no_redirect", {15'd0, redirect}, 16'd0);
    check("squash_in_ready", {15'd0, in_ready}, 16'd1);
    step();
    check("squash_no_valid", {15'd0, out_valid}, 16'd0);
    jump = 0;
    step();
    check("post_squash_valid", {15'd0, out_valid}, 16'd1);
    check("post_squash_a", out_a, 16'h1234);

    // JAL blocked by writeback, then links on the next cycle.
    idle(); in_valid = 1; jump = 1; link = 1; base_pc = 1; pc_next = 16'h0100; imm = 11'h010;
    wr_en = 1; wr_addr = 1; wr_data = 16'h5555;
    #1;
    check("jal_conflict_ready", {15'd0, in_ready}, 16'd0);
    check("jal_conflict_redirect", {15'd0, redirect}, 16'd0);
    step();
    wr_en = 0;
    #1;
    check("jal_ready", {15'd0, in_ready}, 16'd1);
    check("jal_redirect", {15'd0, redirect}, 16'd1);
    check("jal_target", target, 16'h0110);
    step();
    idle();
    step();
    in_valid = 1; rs_addr = 7; rt_addr = 1;
    step();
    check("link_r7", out_a, 16'h0100);
    check("wb_r1", out_b, 16'h5555);

    // Stall together with flush clears valid.
    stall = 1; flush = 1;
    step();
    check("stall_flush_valid", {15'd0, out_valid}, 16'd0);
    stall = 0; flush = 0; rs_addr = 3; rt_addr = 1;
    step();
    check("reload_valid", {15'd0, out_valid}, 16'd1);
    stall = 1; rs_addr = 0; rt_addr = 0; b_imm = 1; imm = 11'h7FF; imm_sel = 2'b10;
    #1;
    check("stall_in_ready", {15'd0, in_ready}, 16'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall%0d_valid", i), {15'd0, out_valid}, 16'd1);
      check($sformatf("stall%0d_a", i), out_a, 16'h1234);
      check($sformatf("stall%0d_b", i), out_b, 16'h5555);
    end

    // Reset in the middle of a taken branch.
    idle(); in_valid = 1; branch = 1; cond = 2'b00; rs_addr = 0; base_pc = 1;
    pc_next = 16'h0200; imm = 11'h004;
    #1;
    check("pre_rst_redirect", {15'd0, redirect}, 16'd1);
    rst = 1;
    #1;
    check("mid_rst_redirect", {15'd0, redirect}, 16'd0);
    step();
    check("mid_rst_valid", {15'd0, out_valid}, 16'd0);
    check("mid_rst_a", out_a, 16'h0000);
    rst = 0; idle(); in_valid = 1; rs_addr = 3; rt_addr = 7;
    step();
    check("after_rst_valid", {15'd0, out_valid}, 16'd1);
    check("after_rst_r3", out_a, 16'h0000);
    check("after_rst_r7", out_b, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
